// File: rtl/pong_game_control_if.sv
// Signal bundle between the pong game controller and its paddle/video neighbours.
// The slave side is the controller itself; the master side drives paddles, grid position and start.
interface pong_game_control_if;
  logic       i_Game_Start;
  logic [5:0] i_Paddle_P1_Y;
  logic [5:0] i_Paddle_P2_Y;
  logic [5:0] i_ColCount_Div;
  logic [5:0] i_RowCount_Div;
  logic       o_Game_Active;
  logic       o_DrawBall;
  logic [5:0] o_Ball_X;
  logic [5:0] o_Ball_Y;
  logic [3:0] o_P1_Score;
  logic [3:0] o_P2_Score;
  logic [1:0] o_Winner;

  modport master (
    output i_Game_Start, i_Paddle_P1_Y, i_Paddle_P2_Y, i_ColCount_Div, i_RowCount_Div,
    input  o_Game_Active, o_DrawBall, o_Ball_X, o_Ball_Y, o_P1_Score, o_P2_Score, o_Winner
  );

  modport slave (
    input  i_Game_Start, i_Paddle_P1_Y, i_Paddle_P2_Y, i_ColCount_Div, i_RowCount_Div,
    output o_Game_Active, o_DrawBall, o_Ball_X, o_Ball_Y, o_P1_Score, o_P2_Score, o_Winner
  );
endinterface

// File: rtl/pong_game_control.sv
// Pong game sequencer: state machine, ball motion, paddle hit/miss, scoring.
// Ball draw strobe has one clock of latency; no backpressure, inputs are sampled every clock.
module pong_game_control #(
  parameter int c_GAME_WINDOW_WIDTH  = 40,
  parameter int c_GAME_WINDOW_HEIGHT = 30,
  parameter int c_PADDLE_HEIGHT      = 6,
  parameter int c_BALL_DELAY_CYCLES  = 1250000,
  parameter int c_SERVE_TICKS        = 20,
  parameter int c_WIN_SCORE          = 9
) (
  input  logic                i_Clk,
  input  logic                i_Reset,
  pong_game_control_if.slave  gif
);

  localparam int CW = (c_BALL_DELAY_CYCLES > 1) ? $clog2(c_BALL_DELAY_CYCLES) : 1;
  localparam int SW = (c_SERVE_TICKS > 1) ? $clog2(c_SERVE_TICKS) : 1;

  localparam logic [CW-1:0] TICK_LAST  = CW'(c_BALL_DELAY_CYCLES - 1);
  localparam logic [SW-1:0] SERVE_LAST = SW'(c_SERVE_TICKS - 1);
  localparam logic [5:0]    X_CENTRE   = 6'(c_GAME_WINDOW_WIDTH / 2);
  localparam logic [5:0]    Y_CENTRE   = 6'(c_GAME_WINDOW_HEIGHT / 2);
  localparam logic [5:0]    X_P1_HIT   = 6'd1;
  localparam logic [5:0]    X_P2_HIT   = 6'(c_GAME_WINDOW_WIDTH - 2);
  localparam logic [5:0]    X_P2_BACK  = 6'(c_GAME_WINDOW_WIDTH - 3);
  localparam logic [5:0]    Y_BOTTOM   = 6'(c_GAME_WINDOW_HEIGHT - 1);
  localparam logic [6:0]    PADDLE_EXT = 7'(c_PADDLE_HEIGHT);
  localparam logic [3:0]    WIN_SCORE  = 4'(c_WIN_SCORE);
  localparam logic [1:0]    WIN_NONE   = 2'b00;
  localparam logic [1:0]    WIN_P1     = 2'b01;
  localparam logic [1:0]    WIN_P2     = 2'b10;

  typedef enum logic [1:0] {IDLE, SERVE, RUNNING, GAME_OVER} state_t;

  state_t        state_q;
  logic [CW-1:0] tick_cnt_q;
  logic [SW-1:0] serve_cnt_q;
  logic [5:0]    ball_x_q, ball_y_q;
  logic          dir_x_q;   // 1 = moving right (towards P2)
  logic          dir_y_q;   // 1 = moving down
  logic [3:0]    p1_score_q, p2_score_q;
  logic [1:0]    winner_q;
  logic          draw_q;

  logic       active, tick;
  logic       p1_cover, p2_cover;
  logic       p1_point, p2_point;
  logic [5:0] ball_x_d, ball_y_d;
  logic       dir_x_d, dir_y_d;
  logic [3:0] p1_score_d, p2_score_d;

  always_comb begin
    active = (state_q == SERVE) || (state_q == RUNNING);
    tick   = active && (tick_cnt_q == TICK_LAST);

    // 7-bit compare so a paddle near the bottom of the 6-bit range cannot wrap.
    p1_cover = ({1'b0, gif.i_Paddle_P1_Y} <= {1'b0, ball_y_q}) &&
               ({1'b0, ball_y_q} <= ({1'b0, gif.i_Paddle_P1_Y} + PADDLE_EXT));
    p2_cover = ({1'b0, gif.i_Paddle_P2_Y} <= {1'b0, ball_y_q}) &&
               ({1'b0, ball_y_q} <= ({1'b0, gif.i_Paddle_P2_Y} + PADDLE_EXT));

    dir_y_d  = dir_y_q;
    ball_y_d = ball_y_q;
    if (dir_y_q) begin
      if (ball_y_q == Y_BOTTOM) begin
        dir_y_d  = 1'b0;
        ball_y_d = ball_y_q - 6'd1;
      end else begin
        ball_y_d = ball_y_q + 6'd1;
      end
    end else begin
      if (ball_y_q == 6'd0) begin
        dir_y_d  = 1'b1;
        ball_y_d = ball_y_q + 6'd1;
      end else begin
        ball_y_d = ball_y_q - 6'd1;
      end
    end

    dir_x_d  = dir_x_q;
    ball_x_d = ball_x_q;
    p1_point = 1'b0;
    p2_point = 1'b0;
    if (!dir_x_q && (ball_x_q == X_P1_HIT)) begin
      if (p1_cover) begin
        dir_x_d  = 1'b1;
        ball_x_d = 6'd2;
      end else begin
        p2_point = 1'b1;
      end
    end else if (dir_x_q && (ball_x_q == X_P2_HIT)) begin
      if (p2_cover) begin
        dir_x_d  = 1'b0;
        ball_x_d = X_P2_BACK;
      end else begin
        p1_point = 1'b1;
      end
    end else begin
      ball_x_d = dir_x_q ? (ball_x_q + 6'd1) : (ball_x_q - 6'd1);
    end

    p1_score_d = (p1_score_q == 4'd15) ? 4'd15 : (p1_score_q + 4'd1);
    p2_score_d = (p2_score_q == 4'd15) ? 4'd15 : (p2_score_q + 4'd1);
  end

  always_ff @(posedge i_Clk or posedge i_Reset) begin
    if (i_Reset) begin
      state_q     <= IDLE;
      tick_cnt_q  <= '0;
      serve_cnt_q <= '0;
      ball_x_q    <= X_CENTRE;
      ball_y_q    <= Y_CENTRE;
      dir_x_q     <= 1'b1;
      dir_y_q     <= 1'b1;
      p1_score_q  <= 4'd0;
      p2_score_q  <= 4'd0;
      winner_q    <= WIN_NONE;
      draw_q      <= 1'b0;
    end else begin
      draw_q <= active && (gif.i_ColCount_Div == ball_x_q) && (gif.i_RowCount_Div == ball_y_q);
      if (active) begin
        tick_cnt_q <= tick ? '0 : (tick_cnt_q + CW'(1));
      end

      case (state_q)
        IDLE, GAME_OVER: begin
          tick_cnt_q <= '0;
          if (gif.i_Game_Start) begin
            state_q     <= SERVE;
            serve_cnt_q <= '0;
            ball_x_q    <= X_CENTRE;
            ball_y_q    <= Y_CENTRE;
            dir_x_q     <= 1'b1;
            dir_y_q     <= 1'b1;
            p1_score_q  <= 4'd0;
            p2_score_q  <= 4'd0;
            winner_q    <= WIN_NONE;
          end
        end

        SERVE: begin
          if (tick) begin
            if (serve_cnt_q == SERVE_LAST) begin
              state_q     <= RUNNING;
              serve_cnt_q <= '0;
            end else begin
              serve_cnt_q <= serve_cnt_q + SW'(1);
            end
          end
        end

        RUNNING: begin
          if (tick) begin
            if (p1_point || p2_point) begin
              // Rally over: re-centre and serve towards whoever just conceded.
              ball_x_q    <= X_CENTRE;
              ball_y_q    <= Y_CENTRE;
              serve_cnt_q <= '0;
              tick_cnt_q  <= '0;
              if (p1_point) begin
                p1_score_q <= p1_score_d;
                dir_x_q    <= 1'b1;
                if (p1_score_d == WIN_SCORE) begin
                  state_q  <= GAME_OVER;
                  winner_q <= WIN_P1;
                end else begin
                  state_q <= SERVE;
                end
              end else begin
                p2_score_q <= p2_score_d;
                dir_x_q    <= 1'b0;
                if (p2_score_d == WIN_SCORE) begin
                  state_q  <= GAME_OVER;
                  winner_q <= WIN_P2;
                end else begin
                  state_q <= SERVE;
                end
              end
            end else begin
              ball_x_q <= ball_x_d;
              ball_y_q <= ball_y_d;
              dir_x_q  <= dir_x_d;
              dir_y_q  <= dir_y_d;
            end
          end
        end

        default: state_q <= IDLE;
      endcase
    end
  end

  assign gif.o_Game_Active = active;
  assign gif.o_DrawBall    = draw_q;
  assign gif.o_Ball_X      = ball_x_q;
  assign gif.o_Ball_Y      = ball_y_q;
  assign gif.o_P1_Score    = p1_score_q;
  assign gif.o_P2_Score    = p2_score_q;
  assign gif.o_Winner      = winner_q;

endmodule
